// File: rtl/pattern_engine_pkg.sv
// Mode encodings, trigger bit positions and the shared generator step function.
// Pure declarations only: no state, no timing.
package pattern_engine_pkg;

   localparam int STEP_MAX_W = 64;

   localparam int TRIG_LFSR    = 0;
   localparam int TRIG_COUNTER = 1;
   localparam int TRIG_OFF     = 2;
   localparam int TRIG_CONT    = 3;
   localparam int TRIG_PIPED   = 4;

   typedef enum logic {
      GEN_LFSR    = 1'b0,
      GEN_COUNTER = 1'b1
   } gen_mode_e;

   typedef enum logic [1:0] {
      REF_OFF   = 2'd0,
      REF_CONT  = 2'd1,
      REF_PIPED = 2'd2
   } refresh_e;

   // Values are carried in a 64-bit container; w selects the live width (w <= 64).
   function automatic logic [STEP_MAX_W-1:0] step_state(
      input logic [STEP_MAX_W-1:0] s,
      input logic [STEP_MAX_W-1:0] taps,
      input int unsigned           w,
      input gen_mode_e             mode
   );
      logic [STEP_MAX_W-1:0] mask;
      mask = (w >= STEP_MAX_W) ? '1 : ((64'd1 << w) - 64'd1);
      if (mode == GEN_COUNTER) begin
         return (s + 64'd1) & mask;
      end
      return ((s << 1) | {63'd0, ^(s & taps & mask)}) & mask;
   endfunction

endpackage

// File: rtl/pattern_engine_if.sv
// PipeOut/PipeIn endpoint signals; the engine is the slave side.
// Strobes are single-cycle, no backpressure on either pipe.
interface pattern_engine_if #(
   parameter int DATA_W = 16
);
   logic              pipe_read;
   logic [DATA_W-1:0] pipe_dout;
   logic              pipe_write;
   logic [DATA_W-1:0] pipe_din;

   modport master (output pipe_read, pipe_write, pipe_din, input pipe_dout);
   modport slave  (input pipe_read, pipe_write, pipe_din, output pipe_dout);
endinterface

// File: rtl/pattern_checker.sv
// Loopback checker: compares PipeIn words to its own expected stream, counts words and errors.
// Outputs update one cycle after pipe_write/chk_clear; never stalls the writer.
module pattern_checker
   import pattern_engine_pkg::*;
#(
   parameter int                DATA_W   = 16,
   parameter int                LFSR_W   = 32,
   parameter logic [LFSR_W-1:0] TAP_MASK = 32'h8020_0002,
   parameter int                ERR_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  gen_mode_e         gen_mode,
   input  logic [LFSR_W-1:0] seed,
   input  logic              seed_load,
   input  logic              pipe_write,
   input  logic [DATA_W-1:0] pipe_din,
   input  logic              chk_clear,
   output logic [ERR_W-1:0]  err_count,
   output logic [31:0]       word_count,
   output logic              mismatch
);
   logic [LFSR_W-1:0] exp_q, exp_d;
   logic [ERR_W-1:0]  err_q, err_d;
   logic [31:0]       wc_q, wc_d;
   logic              mis_q, mis_d;

   always_comb begin
      exp_d = exp_q;
      err_d = err_q;
      wc_d  = wc_q;
      mis_d = mis_q;
      if (pipe_write) begin
         exp_d = LFSR_W'(step_state(64'(exp_q), 64'(TAP_MASK), LFSR_W, gen_mode));
      end
      if (seed_load) begin
         exp_d = seed;
      end
      // Clear wins over counting, but the expected stream still advances.
      if (chk_clear) begin
         err_d = '0;
         wc_d  = '0;
         mis_d = 1'b0;
      end else if (pipe_write) begin
         wc_d = wc_q + 32'd1;
         if (pipe_din != exp_q[DATA_W-1:0]) begin
            mis_d = 1'b1;
            if (err_q != '1) begin
               err_d = err_q + ERR_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q <= LFSR_W'(1);
         err_q <= '0;
         wc_q  <= '0;
         mis_q <= 1'b0;
      end else begin
         exp_q <= exp_d;
         err_q <= err_d;
         wc_q  <= wc_d;
         mis_q <= mis_d;
      end
   end

   assign err_count  = err_q;
   assign word_count = wc_q;
   assign mismatch   = mis_q;
endmodule

// File: rtl/pattern_engine.sv
// N_CH LFSR/counter generators served round-robin to PipeOut, plus a PipeIn loopback checker.
// pipe_dout valid one cycle after pipe_read; back-to-back reads every cycle, no stall.
module pattern_engine
   import pattern_engine_pkg::*;
#(
   parameter int                DATA_W   = 16,
   parameter int                LFSR_W   = 32,
   parameter int                N_CH     = 4,
   parameter logic [LFSR_W-1:0] TAP_MASK = 32'h8020_0002,
   parameter int                ERR_W    = 16,
   localparam int               CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic               ti_clk,
   input  logic               reset,
   input  logic [4:0]         mode_trig,
   input  logic [LFSR_W-1:0]  seed,
   input  logic [CH_W-1:0]    seed_ch,
   input  logic               seed_load,
   input  logic               chk_clear,
   pattern_engine_if.slave    pipe,
   output logic [DATA_W-1:0]  status_word,
   output logic [ERR_W-1:0]   err_count,
   output logic [31:0]        word_count,
   output logic               mismatch
);
   logic [LFSR_W-1:0] state_q [N_CH];
   logic [LFSR_W-1:0] state_d [N_CH];
   gen_mode_e         gen_q, gen_d;
   refresh_e          ref_q, ref_d;
   logic [CH_W-1:0]   rr_q, rr_d;
   logic [DATA_W-1:0] dout_q, dout_d, status_q, rd_word;

   always_comb begin
      gen_d = gen_q;
      if (mode_trig[TRIG_LFSR])         gen_d = GEN_LFSR;
      else if (mode_trig[TRIG_COUNTER]) gen_d = GEN_COUNTER;

      ref_d = ref_q;
      if (mode_trig[TRIG_OFF])        ref_d = REF_OFF;
      else if (mode_trig[TRIG_CONT])  ref_d = REF_CONT;
      else if (mode_trig[TRIG_PIPED]) ref_d = REF_PIPED;

      rd_word = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (rr_q == CH_W'(k)) rd_word = state_q[k][DATA_W-1:0];
      end

      // A seed load overrides whatever step the channel would take this cycle.
      for (int k = 0; k < N_CH; k++) begin
         state_d[k] = state_q[k];
         if (ref_q == REF_CONT ||
             (ref_q == REF_PIPED && pipe.pipe_read && rr_q == CH_W'(k))) begin
            state_d[k] = LFSR_W'(step_state(64'(state_q[k]), 64'(TAP_MASK), LFSR_W, gen_q));
         end
         if (seed_load && seed_ch == CH_W'(k)) state_d[k] = seed;
      end

      dout_d = pipe.pipe_read ? rd_word : dout_q;
      rr_d   = rr_q;
      if (pipe.pipe_read) begin
         rr_d = (rr_q == CH_W'(N_CH - 1)) ? '0 : rr_q + CH_W'(1);
      end
   end

   always_ff @(posedge ti_clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < N_CH; k++) state_q[k] <= LFSR_W'(k + 1);
         gen_q    <= GEN_LFSR;
         ref_q    <= REF_OFF;
         rr_q     <= '0;
         dout_q   <= '0;
         status_q <= '0;
      end else begin
         for (int k = 0; k < N_CH; k++) state_q[k] <= state_d[k];
         gen_q    <= gen_d;
         ref_q    <= ref_d;
         rr_q     <= rr_d;
         dout_q   <= dout_d;
         status_q <= state_q[0][DATA_W-1:0];
      end
   end

   assign pipe.pipe_dout = dout_q;
   assign status_word    = status_q;

   pattern_checker #(
      .DATA_W   (DATA_W),
      .LFSR_W   (LFSR_W),
      .TAP_MASK (TAP_MASK),
      .ERR_W    (ERR_W)
   ) u_checker (
      .clk        (ti_clk),
      .rst        (reset),
      .gen_mode   (gen_q),
      .seed       (seed),
      .seed_load  (seed_load && seed_ch == '0),
      .pipe_write (pipe.pipe_write),
      .pipe_din   (pipe.pipe_din),
      .chk_clear  (chk_clear),
      .err_count  (err_count),
      .word_count (word_count),
      .mismatch   (mismatch)
   );
endmodule

// File: tb/tb_pattern_engine.sv
// Two engines (N_CH=4/ERR_W=16 and N_CH=1/ERR_W=4) share one stimulus stream and are checked
// every cycle against an array-based model, plus directed literal expectations.
module tb_pattern_engine;
   logic        ti_clk = 1'b0;
   logic        reset = 1'b1;
   logic [4:0]  mode_trig = '0;
   logic [31:0] seed = '0;
   logic [1:0]  seed_ch = '0;
   logic        seed_load = 1'b0, pipe_read = 1'b0, pipe_write = 1'b0, chk_clear = 1'b0;
   logic [15:0] pipe_din = '0;

   logic [15:0] status_a, status_b, err_a;
   logic [3:0]  err_b;
   logic [31:0] wc_a, wc_b;
   logic        mis_a, mis_b;

   int checks = 0;
   int failures = 0;
   bit started = 0;

   always #5 ti_clk = ~ti_clk;

   pattern_engine_if #(.DATA_W(16)) if_a ();
   pattern_engine_if #(.DATA_W(16)) if_b ();
   assign if_a.pipe_read = pipe_read;  assign if_b.pipe_read = pipe_read;
   assign if_a.pipe_write = pipe_write; assign if_b.pipe_write = pipe_write;
   assign if_a.pipe_din = pipe_din;    assign if_b.pipe_din = pipe_din;

   pattern_engine #(.DATA_W(16), .LFSR_W(32), .N_CH(4), .TAP_MASK(32'h8020_0002), .ERR_W(16)) dut_a (
      .ti_clk(ti_clk), .reset(reset), .mode_trig(mode_trig), .seed(seed), .seed_ch(seed_ch),
      .seed_load(seed_load), .chk_clear(chk_clear), .pipe(if_a), .status_word(status_a),
      .err_count(err_a), .word_count(wc_a), .mismatch(mis_a));

   // Single-channel engine sees only bit 0 of seed_ch, so seed_ch=1 exercises the ignored case.
   pattern_engine #(.DATA_W(16), .LFSR_W(32), .N_CH(1), .TAP_MASK(32'h8020_0002), .ERR_W(4)) dut_b (
      .ti_clk(ti_clk), .reset(reset), .mode_trig(mode_trig), .seed(seed), .seed_ch(seed_ch[0:0]),
      .seed_load(seed_load), .chk_clear(chk_clear), .pipe(if_b), .status_word(status_b),
      .err_count(err_b), .word_count(wc_b), .mismatch(mis_b));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_state [2][4];
   int          m_rr [2];
   logic [15:0] m_dout [2], m_status [2];
   logic [31:0] m_exp [2], m_wc [2];
   int          m_err [2];
   bit          m_mis [2];
   bit          m_lfsr;
   int          m_ref;   // 0 off, 1 continuous, 2 piped

   function automatic logic [31:0] m_step(input logic [31:0] s, input bit lfsr);
      logic [31:0] taps = 32'h8020_0002;
      bit fb = 1'b0;
      if (!lfsr) return s + 32'd1;
      for (int i = 0; i < 32; i++) if (taps[i] && s[i]) fb = ~fb;
      return {s[30:0], fb};
   endfunction

   function automatic void m_reset();
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < 4; k++) m_state[d][k] = 32'(k + 1);
         m_rr[d] = 0; m_dout[d] = '0; m_status[d] = '0;
         m_exp[d] = 32'd1; m_wc[d] = '0; m_err[d] = 0; m_mis[d] = 1'b0;
      end
      m_lfsr = 1'b1;
      m_ref = 0;
   endfunction

   function automatic void m_update();
      for (int d = 0; d < 2; d++) begin
         int n    = (d == 0) ? 4 : 1;
         int emax = (d == 0) ? 65535 : 15;
         int tgt  = (d == 0) ? int'(seed_ch) : int'(seed_ch[0]);
         logic [31:0] old [4];
         for (int k = 0; k < 4; k++) old[k] = m_state[d][k];
         if (pipe_read) m_dout[d] = old[m_rr[d]][15:0];
         m_status[d] = old[0][15:0];
         for (int k = 0; k < n; k++) begin
            if (m_ref == 1 || (m_ref == 2 && pipe_read && m_rr[d] == k))
               m_state[d][k] = m_step(old[k], m_lfsr);
            if (seed_load && tgt == k) m_state[d][k] = seed;
         end
         if (pipe_read) m_rr[d] = (m_rr[d] + 1) % n;
         if (chk_clear) begin
            m_err[d] = 0; m_wc[d] = '0; m_mis[d] = 1'b0;
         end else if (pipe_write) begin
            m_wc[d] = m_wc[d] + 1;
            if (pipe_din != m_exp[d][15:0]) begin
               if (m_err[d] < emax) m_err[d]++;
               m_mis[d] = 1'b1;
            end
         end
         if (seed_load && tgt == 0) m_exp[d] = seed;
         else if (pipe_write) m_exp[d] = m_step(m_exp[d], m_lfsr);
      end
      if (mode_trig[0]) m_lfsr = 1'b1;
      else if (mode_trig[1]) m_lfsr = 1'b0;
      if (mode_trig[2]) m_ref = 0;
      else if (mode_trig[3]) m_ref = 1;
      else if (mode_trig[4]) m_ref = 2;
   endfunction

   initial forever begin
      @(posedge ti_clk or posedge reset);
      if (reset) m_reset();
      else m_update();
   end

   initial begin
      wait (started);
      forever begin
         @(negedge ti_clk);
         chk("dout_a", 32'(if_a.pipe_dout), 32'(m_dout[0]));
         chk("dout_b", 32'(if_b.pipe_dout), 32'(m_dout[1]));
         chk("status_a", 32'(status_a), 32'(m_status[0]));
         chk("status_b", 32'(status_b), 32'(m_status[1]));
         chk("err_a", 32'(err_a), 32'(m_err[0]));
         chk("err_b", 32'(err_b), 32'(m_err[1]));
         chk("wc_a", wc_a, m_wc[0]);
         chk("wc_b", wc_b, m_wc[1]);
         chk("mis_a", 32'(mis_a), 32'(m_mis[0]));
         chk("mis_b", 32'(mis_b), 32'(m_mis[1]));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc();
      @(posedge ti_clk);
      #2;
   endtask

   task automatic idle();
      mode_trig = '0; seed_load = 1'b0; pipe_read = 1'b0; pipe_write = 1'b0; chk_clear = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      cyc(); cyc();
      reset = 1'b0;
      cyc();
   endtask

   task automatic trig(input logic [4:0] t);
      mode_trig = t;
      cyc();
      mode_trig = '0;
   endtask

   int exp_rr [8] = '{1, 2, 3, 4, 2, 3, 4, 5};
   int exp_lf [5] = '{16'h0001, 16'h0002, 16'h0005, 16'h000A, 16'h0015};
   logic [15:0] s0;

   initial begin
      cyc();
      started = 1;
      cyc();
      chk("rst_dout_a", 32'(if_a.pipe_dout), 32'h0);
      chk("rst_err_a", 32'(err_a), 32'h0);
      chk("rst_wc_b", wc_b, 32'h0);
      reset = 1'b0;
      cyc();
      chk("post_rst_status_a", 32'(status_a), 32'h1);

      // COUNTER + PIPED, round-robin over 4 channels
      trig(5'b10010);
      pipe_read = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cyc();
         chk("rr_counter_a", 32'(if_a.pipe_dout), 32'(exp_rr[i]));
      end
      idle();

      // LFSR (bit0 beats bit1) + PIPED, channel 0 seeded with 1
      do_reset();
      mode_trig = 5'b10011; seed = 32'd1; seed_ch = 2'd0; seed_load = 1'b1;
      cyc();
      idle();
      pipe_read = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("lfsr_seq_b", 32'(if_b.pipe_dout), 32'(exp_lf[i]));
      end
      chk("lfsr_rr_wrap_a", 32'(if_a.pipe_dout), 32'h2);
      idle();

      // COUNTER + CONTINUOUS, then OFF (bit2 beats bits 3,4)
      do_reset();
      trig(5'b01010);
      cyc();
      s0 = status_a;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("cont_inc_a", 32'(status_a), 32'(s0 + 16'(i + 1)));
      end
      trig(5'b11100);
      cyc();
      s0 = status_a;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("off_freeze_a", 32'(status_a), 32'(s0));
      end

      // Loopback of 100 words on the 1-channel engine, word 50 corrupted
      do_reset();
      trig(5'b10000);
      pipe_read = 1'b1;
      cyc();
      for (int i = 0; i < 100; i++) begin
         if (i == 50) begin
            chk("loop_clean_err_b", 32'(err_b), 32'h0);
            chk("loop_clean_wc_b", wc_b, 32'd50);
         end
         pipe_write = 1'b1;
         pipe_din = if_b.pipe_dout ^ ((i == 50) ? 16'h0001 : 16'h0000);
         pipe_read = (i < 99);
         cyc();
      end
      idle();
      cyc();
      chk("loop_err_b", 32'(err_b), 32'h1);
      chk("loop_wc_b", wc_b, 32'd100);
      chk("loop_mis_b", 32'(mis_b), 32'h1);
      chk_clear = 1'b1;
      cyc();
      idle();
      chk("clear_err_b", 32'(err_b), 32'h0);
      chk("clear_wc_b", wc_b, 32'h0);
      chk("clear_mis_b", 32'(mis_b), 32'h0);

      // 20 wrong words: 4-bit counter saturates at 15
      do_reset();
      trig(5'b00010);
      pipe_din = 16'h0000;
      pipe_write = 1'b1;
      repeat (20) cyc();
      idle();
      cyc();
      chk("sat_err_b", 32'(err_b), 32'd15);
      chk("sat_wc_b", wc_b, 32'd20);
      chk("sat_err_a", 32'(err_a), 32'd20);

      // Out-of-range seed_ch, then same-cycle read + seed on channel 0
      do_reset();
      trig(5'b10010);
      seed = 32'h0000_BEEF; seed_ch = 2'd1; seed_load = 1'b1;
      cyc();
      idle();
      seed_ch = 2'd0;
      pipe_read = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cyc();
         chk("ramp_b", 32'(if_b.pipe_dout), 32'(i + 1));
         if (i == 1) chk("seed_ch1_a", 32'(if_a.pipe_dout), 32'h0000_BEEF);
      end
      seed = 32'h0000_0100; seed_load = 1'b1;
      cyc();
      seed_load = 1'b0;
      chk("collide_pre_b", 32'(if_b.pipe_dout), 32'h7);
      cyc();
      chk("collide_post_b", 32'(if_b.pipe_dout), 32'h100);

      // Mid-stream reset while reads continue
      reset = 1'b1;
      #1;
      chk("async_rst_b", 32'(if_b.pipe_dout), 32'h0);
      cyc();
      reset = 1'b0;
      cyc();
      chk("first_after_rst_b", 32'(if_b.pipe_dout), 32'h1);
      chk("first_after_rst_a", 32'(if_a.pipe_dout), 32'h1);
      idle();
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pattern_engine.md
# pattern_engine

Multi-channel test-pattern generator and loopback checker for the host-interface sample designs, clocked from `ti_clk`. It holds `N_CH` independent LFSR/counter generators. In piped mode it serves their low words round-robin to a PipeOut endpoint. A built-in checker compares PipeIn words against an expected stream and counts mismatches. Endpoint wrappers (WireIn/TriggerIn/PipeIn/PipeOut/WireOut) connect outside this block.

## Interface
Parameters:
- `DATA_W`, 16: pipe/status word width.
- `LFSR_W`, 32: generator state width; must be ≥ `DATA_W`.
- `N_CH`, 4: generator channel count, 1..16.
- `TAP_MASK`, 32'h8020_0002: feedback taps, one bit per tap, LSB-aligned to `LFSR_W`.
- `ERR_W`, 16: error-counter width.

Ports:
- `ti_clk` in 1: sole clock.
- `reset` in 1: asynchronous, active-high.
- `mode_trig` in 5: one-cycle trigger pulses. [0] LFSR, [1] COUNTER, [2] OFF, [3] CONTINUOUS, [4] PIPED.
- `seed` in LFSR_W: seed value.
- `seed_ch` in clog2(N_CH) (min 1): channel targeted by `seed_load`.
- `seed_load` in 1: one-cycle pulse.
- `pipe_read` in 1: PipeOut read strobe.
- `pipe_dout` out DATA_W: PipeOut data.
- `pipe_write` in 1: PipeIn write strobe.
- `pipe_din` in DATA_W: PipeIn data.
- `chk_clear` in 1: clears checker counters.
- `status_word` out DATA_W: channel 0 low word.
- `err_count` out ERR_W: saturating mismatch count.
- `word_count` out 32: words checked, wraps.
- `mismatch` out 1: sticky, set on any mismatch.

## Operation
- Two mode registers:
  - `gen_mode` ∈ {LFSR, COUNTER}; reset LFSR.
  - `refresh` ∈ {OFF, CONTINUOUS, PIPED}; reset OFF.
- Trigger decode:
  - Bits [1:0] and [4:2] are decoded independently.
  - Within each group the lowest set bit wins. An all-zero group leaves its register unchanged.
  - New mode applies from the next cycle.
- Step function:
  - LFSR: `{s[LFSR_W-2:0], ^(s & TAP_MASK)}`.
  - COUNTER: `s+1` mod 2^LFSR_W.
  - All channels share `gen_mode`.
- Reset state: channel k = k+1, so no channel starts in LFSR lock-up. `rr_ptr`=0.
- Behaviour by `refresh` mode:
  - OFF: states hold.
  - CONTINUOUS: every channel steps every cycle.
  - PIPED: only the channel read by `pipe_read` steps.
- On `pipe_read`, in any mode:
  - `pipe_dout <= state[rr_ptr][DATA_W-1:0]`.
  - `rr_ptr` increments, wrapping from N_CH-1 to 0.
  - In PIPED, `state[rr_ptr]` also steps.
- `seed_load`: `state[seed_ch] <= seed`, overriding any step of that channel in the same cycle. `seed_ch ≥ N_CH` is ignored.
- Checker:
  - Holds its own `exp` register (LFSR_W bits); reset value 1.
  - Loaded with `seed` whenever `seed_load` targets channel 0.
  - On `pipe_write`:
    - Compare `pipe_din` with `exp[DATA_W-1:0]`.
    - `word_count++`.
    - On mismatch, `err_count++` (saturating at all-ones) and set `mismatch`.
    - `exp` then steps using `gen_mode`, regardless of `refresh`.
  - `chk_clear` zeros `err_count`, `word_count` and `mismatch`. It has priority over a same-cycle `pipe_write` count, but `exp` still steps.
- `status_word <= state[0][DATA_W-1:0]` every cycle.

## Timing
- Reset values: `pipe_dout`=0, `status_word`=0, `err_count`=0, `word_count`=0, `mismatch`=0.
- `pipe_dout` is valid the cycle after `pipe_read` and holds until the next read.
- `status_word` lags channel 0 state by one cycle.
- Checker outputs update one cycle after `pipe_write`/`chk_clear`.
- Simultaneous `pipe_read` and `seed_load` on the same channel: `pipe_dout` gets the pre-load value; the next read of that channel returns `seed` low bits.
- Back-to-back `pipe_read` every cycle is supported without stall.
- Reset asserted mid-stream: all state returns to reset values immediately. The first post-reset read returns 1.

## Structure
- Package `pattern_engine_pkg` holds:
  - Mode encodings: GEN_LFSR/GEN_COUNTER and REF_OFF/REF_CONT/REF_PIPED.
  - Trigger bit indices.
  - The pure step function, parametrised by width and taps.
- One sub-module, `pattern_checker`, contains `exp`, the counters and `mismatch`. The top level contains the channel array, mode registers, round-robin pointer and pipe register.

## Test plan
- N_CH=4, COUNTER+PIPED, 8 reads → `pipe_dout` 1,2,3,4,2,3,4,5.
- N_CH=1, LFSR+PIPED, seed ch0=1 → reads 0x0001, 0x0002, 0x0005, 0x000A, 0x0015.
- COUNTER+CONTINUOUS after reset → `status_word` increments by 1 per cycle. OFF trigger → value freezes.
- N_CH=1 loopback of 100 `pipe_dout` words into `pipe_din` → `err_count`=0, `word_count`=100. Corrupt word 50 → `err_count`=1, `mismatch`=1. `chk_clear` → all 0.
- ERR_W=4, 20 wrong words → `err_count`=15, `word_count`=20.
- COUNTER, ch0 state 7, `seed_load` 0x100 with same-cycle `pipe_read` → `pipe_dout`=7, next read 0x100. Assert `reset` mid-stream → next read 1.
